ipif_reg_master: RTL and testbench

- Initiator side of the IPIF register interface used by the peripheral user_logic blocks.
- Takes single register commands from an internal controller (game logic, test sequencer) over a valid/ready port.
- Drives Bus2IP_Data/BE/RdCE/WrCE toward a slave, waits for IP2Bus_RdAck/WrAck, and returns read data and status over a valid/ready response port.
- Watchdog counter converts a missing acknowledge into a timeout response.

---
 rtl/ipif_pkg.sv | 33 +++
 rtl/ipif_reg_master_if.sv | 45 ++++
 rtl/ipif_ack_timer.sv | 25 ++
 rtl/ipif_reg_master.sv | 109 ++++++++++
 tb/tb_ipif_reg_master.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ipif_pkg.sv
// Shared types and helpers for the IPIF register initiator.
package ipif_pkg;

    localparam int unsigned MAX_NUM_REG = 64;
    localparam int unsigned TIMER_W     = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    // Bits needed to index n registers (0 for n <= 1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // One-hot chip-enable for register idx; all zeros when idx is out of range.
    function automatic logic [MAX_NUM_REG-1:0] onehot(input int unsigned idx,
                                                      input int unsigned n);
        logic [MAX_NUM_REG-1:0] v;
        v = '0;
        if (idx < n && idx < MAX_NUM_REG) v = MAX_NUM_REG'(1) << idx;
        return v;
    endfunction

endpackage

// File: rtl/ipif_reg_master_if.sv
// Command/response port and IPIF slave bus of the register initiator.
interface ipif_reg_master_if #(
    parameter int unsigned C_NUM_REG    = 1,
    parameter int unsigned C_SLV_DWIDTH = 32,
    parameter int unsigned C_REG_AW     = 1
);
    localparam int unsigned BE_W = C_SLV_DWIDTH / 8;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_rnw;
    logic [C_REG_AW-1:0]     cmd_reg;
    logic [C_SLV_DWIDTH-1:0] cmd_data;
    logic [BE_W-1:0]         cmd_be;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [C_SLV_DWIDTH-1:0] rsp_data;
    logic                    rsp_error;
    logic                    rsp_timeout;

    logic [C_SLV_DWIDTH-1:0] Bus2IP_Data;
    logic [BE_W-1:0]         Bus2IP_BE;
    logic [C_NUM_REG-1:0]    Bus2IP_RdCE;
    logic [C_NUM_REG-1:0]    Bus2IP_WrCE;
    logic [C_SLV_DWIDTH-1:0] IP2Bus_Data;
    logic                    IP2Bus_RdAck;
    logic                    IP2Bus_WrAck;
    logic                    IP2Bus_Error;

    modport master (
        input  cmd_valid, cmd_rnw, cmd_reg, cmd_data, cmd_be, rsp_ready,
        input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error,
        output cmd_ready, rsp_valid, rsp_data, rsp_error, rsp_timeout,
        output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE
    );

    modport slave (
        output cmd_valid, cmd_rnw, cmd_reg, cmd_data, cmd_be, rsp_ready,
        output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error, rsp_timeout,
        input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE
    );

endinterface

// File: rtl/ipif_ack_timer.sv
// Acknowledge watchdog: counts enabled cycles, flags the last allowed one.
module ipif_ack_timer
    import ipif_pkg::*;
#(
    parameter int unsigned C_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + TIMER_W'(1);
    end

    // High in the cycle whose edge brings the count to C_TIMEOUT.
    assign tc_c = en && (cnt == TIMER_W'(C_TIMEOUT - 1));

endmodule

// File: rtl/ipif_reg_master.sv
// IPIF register initiator: one command in, one CE access, one response out.
module ipif_reg_master
    import ipif_pkg::*;
#(
    parameter int unsigned C_NUM_REG    = 1,
    parameter int unsigned C_SLV_DWIDTH = 32,
    parameter int unsigned C_REG_AW     = (clog2(C_NUM_REG) < 1) ? 1 : clog2(C_NUM_REG),
    parameter int unsigned C_TIMEOUT    = 16
) (
    input  logic               Bus2IP_Clk,
    input  logic               Bus2IP_Reset,
    ipif_reg_master_if.master  bus
);

    localparam int unsigned BE_W = C_SLV_DWIDTH / 8;

    state_t state;
    logic   rnw;
    logic   tc_c;
    logic   ack_c;

    // Only the acknowledge matching the access direction is honoured.
    assign ack_c = rnw ? bus.IP2Bus_RdAck : bus.IP2Bus_WrAck;

    ipif_ack_timer #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_timer (
        .clk  (Bus2IP_Clk),
        .rst  (Bus2IP_Reset),
        .clr  (state != S_ACCESS),
        .en   (state == S_ACCESS),
        .tc_c (tc_c)
    );

    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            state           <= S_IDLE;
            rnw             <= 1'b0;
            bus.cmd_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_data    <= '0;
            bus.rsp_error   <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.Bus2IP_Data <= '0;
            bus.Bus2IP_BE   <= '0;
            bus.Bus2IP_RdCE <= '0;
            bus.Bus2IP_WrCE <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        rnw           <= bus.cmd_rnw;
                        bus.cmd_ready <= 1'b0;
                        if (32'(bus.cmd_reg) >= C_NUM_REG) begin
                            bus.rsp_valid   <= 1'b1;
                            bus.rsp_data    <= '0;
                            bus.rsp_error   <= 1'b1;
                            bus.rsp_timeout <= 1'b0;
                            state           <= S_RESP;
                        end else begin
                            if (bus.cmd_rnw) begin
                                bus.Bus2IP_RdCE <= C_NUM_REG'(onehot(32'(bus.cmd_reg), C_NUM_REG));
                                bus.Bus2IP_BE   <= '1;
                            end else begin
                                bus.Bus2IP_WrCE <= C_NUM_REG'(onehot(32'(bus.cmd_reg), C_NUM_REG));
                                bus.Bus2IP_BE   <= bus.cmd_be;
                            end
                            bus.Bus2IP_Data <= bus.cmd_data;
                            state           <= S_ACCESS;
                        end
                    end
                end

                // Acknowledge takes priority over a coincident timeout.
                S_ACCESS: begin
                    if (ack_c || tc_c) begin
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_data    <= (ack_c && rnw) ? bus.IP2Bus_Data : '0;
                        bus.rsp_error   <= ack_c && bus.IP2Bus_Error;
                        bus.rsp_timeout <= !ack_c;
                        bus.Bus2IP_Data <= '0;
                        bus.Bus2IP_BE   <= BE_W'(0);
                        bus.Bus2IP_RdCE <= '0;
                        bus.Bus2IP_WrCE <= '0;
                        state           <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid   <= 1'b0;
                        bus.rsp_data    <= '0;
                        bus.rsp_error   <= 1'b0;
                        bus.rsp_timeout <= 1'b0;
                        state           <= S_GAP;
                    end
                end

                S_GAP: begin
                    bus.cmd_ready <= 1'b1;
                    state         <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipif_reg_master.sv
// Bench for ipif_reg_master: vector table, corner sequences and random traffic.
module tb_ipif_reg_master;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 3;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ipif_reg_master_if #(.C_NUM_REG(NR), .C_SLV_DWIDTH(DW), .C_REG_AW(AW)) bus ();

    ipif_reg_master #(
        .C_NUM_REG(NR), .C_SLV_DWIDTH(DW), .C_REG_AW(AW), .C_TIMEOUT(TO)
    ) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (rst),
        .bus          (bus.master)
    );

    typedef struct {
        logic          rnw;
        logic [AW-1:0] regi;
        logic [31:0]   data;
        logic [3:0]    be;
        int            ack_dly;   // ack on this CE cycle (1-based); 0 = never
        logic          err;
        logic [31:0]   rdata;
        int            hold;      // cycles rsp_ready stays low
        logic          wrong;     // opposite-direction ack during CE
        logic          stray;     // acks while CE is low
        logic [31:0]   e_data;
        logic          e_err;
        logic          e_to;
        int            e_ce;
        int            e_lat;
    } vec_t;

    // Slave behaviour configured by the tests; bus observations kept by the slave process.
    int          slv_dly = 0;
    logic        slv_err = 1'b0, slv_wrong = 1'b0, slv_stray = 1'b0;
    logic [31:0] slv_rdata = '0, exp_wdata = '0;
    logic [3:0]  exp_be = '0;
    logic        chk_wdata = 1'b0;
    int          cur_run = 0, last_run = 0, runs = 0, bus_bad = 0;
    logic [3:0]  run_rd = '0, run_wr = '0;
    logic        prev_ce = 1'b0;

    always @(posedge clk) begin
        logic ce_any, is_rd, hit;
        #1;
        ce_any = (|bus.Bus2IP_RdCE) || (|bus.Bus2IP_WrCE);
        if (ce_any) begin
            if (!prev_ce) begin
                runs++;
                cur_run = 0;
                run_rd  = '0;
                run_wr  = '0;
            end
            cur_run++;
            run_rd |= bus.Bus2IP_RdCE;
            run_wr |= bus.Bus2IP_WrCE;
            if (bus.Bus2IP_BE !== exp_be || (chk_wdata && bus.Bus2IP_Data !== exp_wdata)) bus_bad++;
            is_rd = |bus.Bus2IP_RdCE;
            hit   = (slv_dly != 0) && (cur_run == slv_dly);
            bus.IP2Bus_RdAck = is_rd ? hit : slv_wrong;
            bus.IP2Bus_WrAck = is_rd ? slv_wrong : hit;
            bus.IP2Bus_Error = hit && slv_err;
            bus.IP2Bus_Data  = (hit && is_rd) ? slv_rdata : $urandom;
        end else begin
            if (prev_ce) last_run = cur_run;
            if (bus.Bus2IP_Data !== '0 || bus.Bus2IP_BE !== '0) bus_bad++;
            bus.IP2Bus_RdAck = slv_stray;
            bus.IP2Bus_WrAck = slv_stray;
            bus.IP2Bus_Error = slv_stray;
            bus.IP2Bus_Data  = $urandom;
        end
        prev_ce = ce_any;
    end

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rnw, input int regi, input logic [31:0] data,
                                input logic [3:0] be, input int dly, input logic err,
                                input logic [31:0] rdata, input int hold, input logic wrong,
                                input logic stray, input logic [31:0] e_data, input logic e_err,
                                input logic e_to, input int e_ce, input int e_lat);
        vec_t v;
        v.rnw = rnw; v.regi = AW'(regi); v.data = data; v.be = be; v.ack_dly = dly;
        v.err = err; v.rdata = rdata; v.hold = hold; v.wrong = wrong; v.stray = stray;
        v.e_data = e_data; v.e_err = e_err; v.e_to = e_to; v.e_ce = e_ce; v.e_lat = e_lat;
        return v;
    endfunction

    // Reference outcome of one command from the interface rules alone.
    function automatic vec_t model(input vec_t v);
        logic oor, acked;
        oor     = 32'(v.regi) >= NR;
        acked   = !oor && v.ack_dly >= 1 && v.ack_dly <= int'(TO);
        v.e_ce  = oor ? 0 : (acked ? v.ack_dly : int'(TO));
        v.e_lat = 1 + v.e_ce;
        v.e_data = (v.rnw && acked) ? v.rdata : 32'h0;
        v.e_err = oor || (acked && v.err);
        v.e_to  = !oor && !acked;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int acc, rcyc, runs0, bad0, k;
        logic [31:0] d0;
        logic e0, t0, stable;
        logic [3:0] exp_vec;
        slv_dly = v.ack_dly; slv_err = v.err; slv_rdata = v.rdata;
        slv_wrong = v.wrong; slv_stray = v.stray;
        exp_wdata = v.data; exp_be = v.rnw ? 4'hF : v.be; chk_wdata = !v.rnw;
        @(negedge clk);
        runs0 = runs; bad0 = bus_bad;
        bus.cmd_rnw = v.rnw; bus.cmd_reg = v.regi; bus.cmd_data = v.data; bus.cmd_be = v.be;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = (v.hold == 0);
        k = 0;
        while (!bus.cmd_ready && k < 100) begin @(negedge clk); k++; end
        if (!bus.cmd_ready) begin
            chk({tag, " accept"}, 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge clk); #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        k = 0;
        while (!bus.rsp_valid && k < 300) begin @(negedge clk); k++; end
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        if (!bus.rsp_valid) return;
        chk({tag, " latency"}, cyc - acc, v.e_lat);
        d0 = bus.rsp_data; e0 = bus.rsp_error; t0 = bus.rsp_timeout; stable = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_data !== d0 || bus.rsp_error !== e0 ||
                bus.rsp_timeout !== t0 || bus.cmd_ready || (|bus.Bus2IP_RdCE) || (|bus.Bus2IP_WrCE))
                stable = 1'b0;
        end
        if (v.hold > 0) chk({tag, " hold stable"}, 32'(stable), 32'd1);
        bus.rsp_ready = 1'b1;
        rcyc = cyc;
        chk({tag, " rsp_data"}, bus.rsp_data, v.e_data);
        chk({tag, " rsp_error"}, 32'(bus.rsp_error), 32'(v.e_err));
        chk({tag, " rsp_timeout"}, 32'(bus.rsp_timeout), 32'(v.e_to));
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'd0);
        k = 0;
        while (!bus.cmd_ready && k < 20) begin @(negedge clk); k++; end
        chk({tag, " ready return"}, cyc - rcyc, 2);
        chk({tag, " ce runs"}, runs - runs0, (v.e_ce > 0) ? 1 : 0);
        if (v.e_ce > 0) begin
            exp_vec = 4'(1 << v.regi);
            chk({tag, " ce cycles"}, last_run, v.e_ce);
            chk({tag, " rdce"}, 32'(run_rd), v.rnw ? 32'(exp_vec) : 32'd0);
            chk({tag, " wrce"}, 32'(run_wr), v.rnw ? 32'd0 : 32'(exp_vec));
        end
        chk({tag, " bus data/be"}, bus_bad - bad0, 0);
    endtask

    task automatic wait_rsp(input string tag);
        int k;
        k = 0;
        while (!bus.rsp_valid && k < 300) begin @(negedge clk); k++; end
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!bus.cmd_ready && k < 100) begin @(negedge clk); k++; end
        chk({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        int acc, rcyc, runs0, bad0;
        logic ok;

        tbl[0] = mk(0, 2, 32'hDEADBEEF, 4'hF, 3,  0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 3,  4);
        tbl[1] = mk(1, 1, 32'h0,        4'h0, 1,  0, 32'h12345678, 0, 0, 0, 32'h12345678, 0, 0, 1,  2);
        tbl[2] = mk(1, 3, 32'h0,        4'h0, 0,  0, 32'hCAFEF00D, 0, 0, 0, 32'h0,        0, 1, 16, 17);
        tbl[3] = mk(0, 5, 32'h55AA55AA, 4'hF, 1,  0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0,  1);
        tbl[4] = mk(0, 0, 32'h0BADF00D, 4'h3, 2,  1, 32'h0,        0, 0, 0, 32'h0,        1, 0, 2,  3);
        tbl[5] = mk(0, 3, 32'h01234567, 4'hC, 16, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 16, 17);
        tbl[6] = mk(0, 1, 32'h89ABCDEF, 4'hF, 17, 0, 32'h0,        0, 0, 0, 32'h0,        0, 1, 16, 17);
        tbl[7] = mk(1, 0, 32'h0,        4'h0, 2,  0, 32'hA5A5A5A5, 3, 1, 1, 32'hA5A5A5A5, 0, 0, 2,  3);
        tbl[8] = mk(0, 1, 32'h13572468, 4'h5, 1,  0, 32'h0,        2, 1, 1, 32'h0,        0, 0, 1,  2);
        tbl[9] = mk(1, 7, 32'h0,        4'h0, 1,  0, 32'hFFFFFFFF, 0, 0, 1, 32'h0,        1, 0, 0,  1);

        bus.cmd_valid = 1'b0; bus.cmd_rnw = 1'b0; bus.cmd_reg = '0;
        bus.cmd_data = '0; bus.cmd_be = '0; bus.rsp_ready = 1'b0;

        #1 rst = 1'b1;
        #2;
        chk("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("reset rsp", {29'd0, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout}, 32'd0);
        chk("reset rsp_data", bus.rsp_data, 32'd0);
        chk("reset ce", {24'd0, bus.Bus2IP_RdCE, bus.Bus2IP_WrCE}, 32'd0);
        chk("reset data/be", bus.Bus2IP_Data | 32'(bus.Bus2IP_BE), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back writes with the response held off for 5 cycles.
        slv_dly = 1; slv_err = 1'b0; slv_wrong = 1'b0; slv_stray = 1'b0;
        exp_wdata = 32'h11111111; exp_be = 4'hF; chk_wdata = 1'b1;
        @(negedge clk);
        runs0 = runs; bad0 = bus_bad;
        bus.cmd_rnw = 1'b0; bus.cmd_reg = AW'(1); bus.cmd_data = 32'h11111111; bus.cmd_be = 4'hF;
        bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b0;
        wait_ready("b2b first");
        acc = cyc;
        @(posedge clk); #1;
        bus.cmd_reg = AW'(2); bus.cmd_data = 32'h22222222;
        @(negedge clk);
        wait_rsp("b2b first");
        chk("b2b first latency", cyc - acc, 2);
        chk("b2b first wrce", 32'(run_wr), 32'h2);
        exp_wdata = 32'h22222222;
        ok = 1'b1;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.cmd_ready || (|bus.Bus2IP_WrCE)) ok = 1'b0;
        end
        chk("b2b held off", 32'(ok), 32'd1);
        bus.rsp_ready = 1'b1;
        rcyc = cyc;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("b2b gap cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("b2b gap wrce", 32'(bus.Bus2IP_WrCE), 32'd0);
        @(negedge clk);
        chk("b2b second accept", 32'(bus.cmd_ready), 32'd1);
        chk("b2b accept cycle", cyc - rcyc, 2);
        @(posedge clk); #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        wait_rsp("b2b second");
        chk("b2b second error", 32'(bus.rsp_error), 32'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("b2b ce runs", runs - runs0, 2);
        chk("b2b second wrce", 32'(run_wr), 32'h4);
        chk("b2b bus data", bus_bad - bad0, 0);
        wait_ready("b2b end");

        // Reset pulse in the second ACCESS cycle of a read.
        slv_dly = 0; exp_be = 4'hF; chk_wdata = 1'b0;
        @(negedge clk);
        bus.cmd_rnw = 1'b1; bus.cmd_reg = AW'(1); bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b1;
        wait_ready("rst accept");
        @(posedge clk); #1 bus.cmd_valid = 1'b0;
        @(posedge clk); #2;
        chk("rst rdce before", 32'(bus.Bus2IP_RdCE), 32'h2);
        rst = 1'b1;
        #1;
        chk("rst rdce async", 32'(bus.Bus2IP_RdCE), 32'd0);
        chk("rst cmd_ready async", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        for (int h = 0; h < 6; h++) begin
            @(negedge clk);
            if (bus.rsp_valid || !bus.cmd_ready || (|bus.Bus2IP_RdCE)) ok = 1'b0;
        end
        chk("rst no response", 32'(ok), 32'd1);
        bus.rsp_ready = 1'b0;
        run_txn(mk(0, 2, 32'hFEEDC0DE, 4'h9, 2, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 2, 3), "post-rst");

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            v.rnw     = 1'($urandom);
            v.regi    = AW'($urandom_range(0, 5));
            v.data    = $urandom;
            v.be      = 4'($urandom);
            v.ack_dly = int'($urandom_range(0, 18));
            v.err     = !v.rnw && ($urandom_range(0, 3) == 0);
            v.rdata   = $urandom;
            v.hold    = int'($urandom_range(0, 3));
            v.wrong   = 1'($urandom);
            v.stray   = 1'($urandom);
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1);
    end

endmodule
